// File: rtl/prbs2_rx_checker_if.sv
// Status/data bundle between the loopback test controller and the two-lane PRBS7 receive checker.
// The controller drives clear and the qualified receive bits; the checker returns lock and counters.
interface prbs2_rx_checker_if;
  logic        CLR;
  logic        DIN_EN;
  logic [1:0]  DIN;
  logic        PHY_INIT;
  logic [1:0]  LOCKED;
  logic [59:0] RECV_CNT;
  logic [63:0] ERR_CNT;

  modport master (
    output CLR, DIN_EN, DIN,
    input  PHY_INIT, LOCKED, RECV_CNT, ERR_CNT
  );

  modport slave (
    input  CLR, DIN_EN, DIN,
    output PHY_INIT, LOCKED, RECV_CNT, ERR_CNT
  );
endinterface

// File: rtl/prbs2_rx_checker.sv
// Two-lane PRBS7 (x^7+x^6+1) receive checker: per-lane predictor alignment, windowed loss-of-lock,
// saturating per-lane error counts and a received-bit count while both lanes are locked.
module prbs2_rx_checker #(
  parameter int LOCK_CNT = 16,
  parameter int LOSS_WIN = 64,
  parameter int LOSS_THR = 8
) (
  input logic               CLK,
  input logic               RST,
  prbs2_rx_checker_if.slave bus
);

  localparam int WW = $clog2(LOSS_WIN + 1);
  localparam logic [0:0] S_HUNT   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic        w_lockedNxt [2];
  logic        w_lockedCur [2];
  logic [31:0] w_errCnt    [2];

  logic        r_phyInit;
  logic [59:0] r_recvCnt;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [0:0]    r_state;
    logic [6:0]    r_sh;
    logic [7:0]    r_match;
    logic [WW-1:0] r_win;
    logic [WW-1:0] r_werr;
    logic [31:0]   r_errCnt;

    logic          w_pred;
    logic          w_err;
    logic          w_hit;
    logic          w_wrap;
    logic          w_lockEvt;
    logic          w_lossEvt;
    logic [7:0]    w_matchInc;
    logic [WW-1:0] w_werrNxt;

    assign w_pred     = r_sh[6] ^ r_sh[5];
    assign w_err      = bus.DIN[g] != w_pred;
    assign w_hit      = !w_err && (r_sh != 7'd0);
    assign w_matchInc = r_match + 8'd1;
    assign w_wrap     = r_win == WW'(LOSS_WIN - 1);
    // A wrap opens a fresh window, so only this cycle's error can be in it.
    assign w_werrNxt  = w_wrap ? WW'(w_err) : r_werr + WW'(w_err);
    assign w_lockEvt  = bus.DIN_EN && (r_state == S_HUNT) && w_hit && (w_matchInc == 8'(LOCK_CNT));
    assign w_lossEvt  = bus.DIN_EN && (r_state == S_LOCKED) && w_err && (w_werrNxt == WW'(LOSS_THR));

    assign w_lockedNxt[g] = (r_state == S_LOCKED) ? !w_lossEvt : w_lockEvt;
    assign w_lockedCur[g] = r_state == S_LOCKED;
    assign w_errCnt[g]    = r_errCnt;

    always_ff @(posedge CLK) begin
      if (RST) begin
        r_state  <= S_HUNT;
        r_sh     <= '0;
        r_match  <= '0;
        r_win    <= '0;
        r_werr   <= '0;
        r_errCnt <= '0;
      end else begin
        r_state <= w_lockedNxt[g] ? S_LOCKED : S_HUNT;
        if (bus.DIN_EN) begin
          if (r_state == S_HUNT) begin
            r_sh    <= {r_sh[5:0], bus.DIN[g]};
            r_match <= w_hit ? w_matchInc : 8'd0;
            if (w_lockEvt) begin
              r_win  <= '0;
              r_werr <= '0;
            end
          end else begin
            // Free-running predictor: a single line error never corrupts the history.
            r_sh   <= {r_sh[5:0], w_pred};
            r_win  <= w_wrap ? '0 : r_win + WW'(1);
            r_werr <= w_werrNxt;
            if (w_lossEvt) r_match <= 8'd0;
            if (w_err && r_errCnt != '1) r_errCnt <= r_errCnt + 32'd1;
          end
        end
        if (bus.CLR) begin
          r_win    <= '0;
          r_werr   <= '0;
          r_errCnt <= '0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_phyInit <= 1'b0;
      r_recvCnt <= '0;
    end else begin
      r_phyInit <= w_lockedNxt[0] & w_lockedNxt[1];
      if (bus.DIN_EN && r_phyInit && r_recvCnt != '1) r_recvCnt <= r_recvCnt + 60'd1;
      if (bus.CLR) r_recvCnt <= '0;
    end
  end

  assign bus.PHY_INIT = r_phyInit;
  assign bus.LOCKED   = {w_lockedCur[1], w_lockedCur[0]};
  assign bus.RECV_CNT = r_recvCnt;
  assign bus.ERR_CNT  = {w_errCnt[1], w_errCnt[0]};

endmodule

// File: tb/tb_prbs2_rx_checker.sv
// Bench for prbs2_rx_checker: table-driven lock/error/gating vectors, directed loss/CLR/saturation
// sequences, then randomized traffic checked every cycle against a behavioural reference model.
module tb_prbs2_rx_checker;
  localparam int LOCK_CNT = 16;
  localparam int LOSS_WIN = 64;
  localparam int LOSS_THR = 8;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  prbs2_rx_checker_if bus();

  prbs2_rx_checker #(
    .LOCK_CNT(LOCK_CNT),
    .LOSS_WIN(LOSS_WIN),
    .LOSS_THR(LOSS_THR)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int nCompared = 0;
  int nMismatched = 0;

  typedef struct {
    int          phase;
    bit          clr;
    bit          en;
    logic [1:0]  inv;
    logic [1:0]  expLocked;
    logic [31:0] expErr0;
    logic [31:0] expErr1;
  } vec_t;
  vec_t vecs[$];

  logic [6:0]  txState [2];

  bit          mLocked [2];
  bit          mHist   [2][7];
  int          mMatch  [2];
  int          mWinPos [2];
  int          mWinErr [2];
  logic [31:0] mErr    [2];
  logic [59:0] mRecv;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int g = 0; g < 2; g++) begin
      mLocked[g] = 1'b0;
      mMatch[g]  = 0;
      mWinPos[g] = 0;
      mWinErr[g] = 0;
      mErr[g]    = '0;
      for (int k = 0; k < 7; k++) mHist[g][k] = 1'b0;
    end
    mRecv = '0;
  endtask

  // mHist[g][k] is the bit seen k+1 samples ago; PRBS7 says x[n] = x[n-7] ^ x[n-6].
  task automatic modelStep(input bit rst, input bit clr, input bit en, input logic [1:0] din);
    bit bothPre;
    if (rst) begin
      modelReset();
      return;
    end
    bothPre = mLocked[0] && mLocked[1];
    if (en) begin
      for (int g = 0; g < 2; g++) begin
        bit pred, err, anyHist, newBit;
        pred = mHist[g][6] ^ mHist[g][5];
        anyHist = 1'b0;
        for (int k = 0; k < 7; k++) anyHist |= mHist[g][k];
        err = din[g] != pred;
        newBit = mLocked[g] ? pred : din[g];
        for (int k = 6; k > 0; k--) mHist[g][k] = mHist[g][k-1];
        mHist[g][0] = newBit;
        if (!mLocked[g]) begin
          mMatch[g] = (!err && anyHist) ? mMatch[g] + 1 : 0;
          if (mMatch[g] == LOCK_CNT) begin
            mLocked[g] = 1'b1;
            mWinPos[g] = 0;
            mWinErr[g] = 0;
          end
        end else begin
          if (err && mErr[g] != 32'hFFFF_FFFF) mErr[g] = mErr[g] + 1;
          if (mWinPos[g] == LOSS_WIN - 1) mWinErr[g] = 0;
          mWinPos[g] = (mWinPos[g] + 1) % LOSS_WIN;
          mWinErr[g] += int'(err);
          if (err && mWinErr[g] >= LOSS_THR) begin
            mLocked[g] = 1'b0;
            mMatch[g] = 0;
          end
        end
      end
    end
    if (en && bothPre && mRecv != '1) mRecv = mRecv + 1;
    if (clr) begin
      mRecv = '0;
      for (int g = 0; g < 2; g++) begin
        mErr[g] = '0;
        mWinPos[g] = 0;
        mWinErr[g] = 0;
      end
    end
  endtask

  task automatic checkOutput();
    checkVal("mdl_locked", {62'd0, bus.LOCKED}, {62'd0, mLocked[1], mLocked[0]});
    checkVal("mdl_phy_init", {63'd0, bus.PHY_INIT}, {63'd0, mLocked[0] && mLocked[1]});
    checkVal("mdl_recv_cnt", {4'd0, bus.RECV_CNT}, {4'd0, mRecv});
    checkVal("mdl_err_cnt", bus.ERR_CNT, {mErr[1], mErr[0]});
  endtask

  // One clock: drive inputs, advance the model on the edge, compare just after it.
  task automatic applyStimulus(input bit rst, input bit clr, input bit en,
                               input logic [1:0] inv, input logic [1:0] zero);
    logic [1:0] din;
    din = 2'($urandom_range(0, 3));
    if (en) begin
      for (int g = 0; g < 2; g++) begin
        bit b;
        b = txState[g][6] ^ txState[g][5];
        txState[g] = {txState[g][5:0], b};
        din[g] = zero[g] ? 1'b0 : (b ^ inv[g]);
      end
    end
    RST = rst;
    bus.CLR = clr;
    bus.DIN_EN = en;
    bus.DIN = din;
    @(posedge CLK);
    modelStep(rst, clr, en, din);
    #1;
    checkOutput();
  endtask

  task automatic applyTable(input int phase);
    foreach (vecs[i]) begin
      if (vecs[i].phase == phase) begin
        applyStimulus(1'b0, vecs[i].clr, vecs[i].en, vecs[i].inv, 2'b00);
        checkVal("tbl_locked", {62'd0, bus.LOCKED}, {62'd0, vecs[i].expLocked});
        checkVal("tbl_phy_init", {63'd0, bus.PHY_INIT}, {63'd0, &vecs[i].expLocked});
        checkVal("tbl_err0", {32'd0, bus.ERR_CNT[31:0]}, {32'd0, vecs[i].expErr0});
        checkVal("tbl_err1", {32'd0, bus.ERR_CNT[63:32]}, {32'd0, vecs[i].expErr1});
      end
    end
  endtask

  task automatic addVec(input int phase, input bit clr, input bit en, input logic [1:0] inv,
                        input logic [1:0] expLocked, input logic [31:0] e0, input logic [31:0] e1);
    vec_t v;
    v.phase = phase; v.clr = clr; v.en = en; v.inv = inv;
    v.expLocked = expLocked; v.expErr0 = e0; v.expErr1 = e1;
    vecs.push_back(v);
  endtask

  initial begin
    // Phase 0: clean lock from reset, both lanes up after edge 7+LOCK_CNT = 23.
    for (int k = 1; k <= 23; k++) addVec(0, 1'b0, 1'b1, 2'b00, (k >= 23) ? 2'b11 : 2'b00, 0, 0);
    // Phase 1: one inverted lane-1 bit while locked.
    addVec(1, 1'b0, 1'b1, 2'b10, 2'b11, 0, 1);
    for (int k = 0; k < 3; k++) addVec(1, 1'b0, 1'b1, 2'b00, 2'b11, 0, 1);
    // Phase 2: DIN_EN toggling; lock on the 23rd enabled edge.
    for (int k = 0; k < 46; k++)
      addVec(2, 1'b0, (k % 2) == 0, 2'b00, ((k % 2) == 0 && k / 2 + 1 >= 23) || k > 44 ? 2'b11 : 2'b00, 0, 0);

    RST = 1'b1;
    bus.CLR = 1'b0;
    bus.DIN_EN = 1'b0;
    bus.DIN = 2'b00;
    txState[0] = 7'h7F;
    txState[1] = 7'h7F;
    modelReset();

    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    checkVal("reset_locked", {62'd0, bus.LOCKED}, 64'd0);
    checkVal("reset_phy_init", {63'd0, bus.PHY_INIT}, 64'd0);
    checkVal("reset_recv_cnt", {4'd0, bus.RECV_CNT}, 64'd0);
    checkVal("reset_err_cnt", bus.ERR_CNT, 64'd0);

    applyTable(0);
    for (int k = 0; k < 1000; k++) applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
    checkVal("clean_recv_1000", {4'd0, bus.RECV_CNT}, 64'd1000);
    checkVal("clean_err_zero", bus.ERR_CNT, 64'd0);

    applyTable(1);

    // Five spread lane-0 errors, then CLR while locked.
    for (int e = 0; e < 5; e++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, 2'b00);
      for (int k = 0; k < 9; k++) applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
    end
    checkVal("pre_clr_err0", {32'd0, bus.ERR_CNT[31:0]}, 64'd5);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 2'b00);
    checkVal("clr_recv", {4'd0, bus.RECV_CNT}, 64'd0);
    checkVal("clr_err", bus.ERR_CNT, 64'd0);
    checkVal("clr_locked", {62'd0, bus.LOCKED}, 64'd3);

    // Eight lane-0 errors inside one window: lock lost on the eighth.
    for (int e = 1; e <= 8; e++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
      applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, 2'b00);
      checkVal("loss_locked", {62'd0, bus.LOCKED}, (e < 8) ? 64'd3 : 64'd2);
    end
    checkVal("loss_err0", {32'd0, bus.ERR_CNT[31:0]}, 64'd8);
    checkVal("loss_phy_init", {63'd0, bus.PHY_INIT}, 64'd0);
    checkVal("loss_recv", {4'd0, bus.RECV_CNT}, 64'd16);
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 2'b01);
    checkVal("loss_recv_stopped", {4'd0, bus.RECV_CNT}, 64'd16);
    checkVal("hunt_err0_held", {32'd0, bus.ERR_CNT[31:0]}, 64'd8);
    for (int k = 1; k <= 23; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
      if (k == 6) checkVal("relock_early", {62'd0, bus.LOCKED}, 64'd2);
    end
    checkVal("relock_locked", {62'd0, bus.LOCKED}, 64'd3);

    // All-zero stream must never lock.
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    for (int k = 0; k < 200; k++) applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 2'b11);
    checkVal("zero_locked", {62'd0, bus.LOCKED}, 64'd0);

    txState[0] = 7'h7F;
    txState[1] = 7'h7F;
    applyTable(2);

    // Saturation of the lane-0 error count.
    force dut.g_lane[0].r_errCnt = 32'hFFFF_FFFF;
    mErr[0] = 32'hFFFF_FFFF;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    release dut.g_lane[0].r_errCnt;
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, 2'b00);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, 2'b00);
    checkVal("sat_err0", {32'd0, bus.ERR_CNT[31:0]}, 64'hFFFF_FFFF);
    checkVal("sat_locked", {62'd0, bus.LOCKED}, 64'd3);

    // Randomized traffic in segments of differing error density.
    for (int seg = 0; seg < 15; seg++) begin
      int rate;
      case ($urandom_range(0, 2))
        0:       rate = 0;
        1:       rate = 3;
        default: rate = 20;
      endcase
      for (int k = 0; k < 100; k++) begin
        logic [1:0] inv;
        bit en, clr;
        en  = $urandom_range(0, 3) != 0;
        clr = $urandom_range(0, 149) == 0;
        inv[0] = $urandom_range(0, 99) < rate;
        inv[1] = $urandom_range(0, 99) < rate;
        applyStimulus(1'b0, clr, en, inv, 2'b00);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
